// File: rtl/vram_write_buffer.sv
// vram_write_buffer
// CPU-side posted write port for text-mode VRAM. CPU register writes build
// {plane, address, data} entries in a small FIFO; the FIFO is drained into
// the character/attribute planes only while the CRTC is outside the active
// display area, using a four-state SETUP/STROBE/HOLD/IDLE bus cycle.
// ADDR_WIDTH is expected to lie in 9..16 (the high pointer byte is loaded
// from cpu_data[ADDR_WIDTH-9:0]).

module vram_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            cpu_data,
    input  logic [1:0]            cpu_address,
    input  logic                  n_write,
    input  logic                  display_active,
    output logic [ADDR_WIDTH-1:0] vram_address,
    output logic [7:0]            vram_data,
    output logic                  n_char_we,
    output logic                  n_attr_we,
    output logic                  bus_grant,
    output logic                  fifo_full,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Plane encoding inside a FIFO entry.
    localparam logic PLANE_CHAR = 1'b0;
    localparam logic PLANE_ATTR = 1'b1;

    typedef struct packed {
        logic                  plane;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  n_write_q;
    logic [ADDR_WIDTH-1:0] pointer_q,      pointer_d;
    logic                  overflow_q,     overflow_d;
    logic [PTR_W-1:0]      wr_ptr_q,       wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,       rd_ptr_d;
    logic [CNT_W-1:0]      count_q,        count_d;
    logic                  fifo_full_q,    fifo_full_d;
    state_t                state_q,        state_d;
    logic [ADDR_WIDTH-1:0] vram_address_q, vram_address_d;
    logic [7:0]            vram_data_q,    vram_data_d;
    logic                  n_char_we_q,    n_char_we_d;
    logic                  n_attr_we_q,    n_attr_we_d;
    logic                  bus_grant_q,    bus_grant_d;

    entry_t                mem [DEPTH];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic   write_event;
    logic   push_req;
    logic   push_accept;
    logic   push_drop;
    logic   pop;
    entry_t push_entry;
    entry_t head;

    assign head = mem[rd_ptr_q];

    // Write-event detection, register map and push acceptance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pointer_d  = pointer_q;
        overflow_d = overflow_q;
        push_entry = '{plane: cpu_address[0], addr: pointer_q, data: cpu_data};

        // One event per falling edge of the strobe, however long it is held.
        write_event = n_write_q & ~n_write;
        push_req    = write_event & cpu_address[1];
        pop         = (state_q == S_HOLD);
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_accept = push_req & ((count_q < DEPTH_C) | pop);
        push_drop   = push_req & ~push_accept;

        if (write_event) begin
            case (cpu_address)
                2'd0: pointer_d[7:0] = cpu_data;
                2'd1: begin
                    pointer_d[ADDR_WIDTH-1:8] = cpu_data[ADDR_WIDTH-9:0];
                    overflow_d                = 1'b0;
                end
                2'd2: ;
                2'd3: pointer_d = pointer_q + ADDR_WIDTH'(1);
                default: ;
            endcase
        end

        if (push_drop) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        fifo_full_d = (count_d == DEPTH_C);
    end

    // Bus-cycle FSM: next state plus the registered VRAM-side outputs.
    always_comb begin
        state_d        = state_q;
        vram_address_d = vram_address_q;
        vram_data_d    = vram_data_q;
        n_char_we_d    = 1'b1;
        n_attr_we_d    = 1'b1;
        bus_grant_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // display_active is only consulted here; a started cycle always finishes.
                if ((count_q != '0) && !display_active) begin
                    state_d        = S_SETUP;
                    bus_grant_d    = 1'b1;
                    vram_address_d = head.addr;
                    vram_data_d    = head.data;
                end
            end
            S_SETUP: begin
                state_d     = S_STROBE;
                bus_grant_d = 1'b1;
                n_char_we_d = (head.plane != PLANE_CHAR);
                n_attr_we_d = (head.plane != PLANE_ATTR);
            end
            S_STROBE: begin
                state_d     = S_HOLD;
                bus_grant_d = 1'b1;
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Control state and registered outputs; reset drops the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            n_write_q      <= 1'b1;
            pointer_q      <= '0;
            overflow_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            fifo_full_q    <= 1'b0;
            state_q        <= S_IDLE;
            vram_address_q <= '0;
            vram_data_q    <= '0;
            n_char_we_q    <= 1'b1;
            n_attr_we_q    <= 1'b1;
            bus_grant_q    <= 1'b0;
        end else begin
            n_write_q      <= n_write;
            pointer_q      <= pointer_d;
            overflow_q     <= overflow_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            fifo_full_q    <= fifo_full_d;
            state_q        <= state_d;
            vram_address_q <= vram_address_d;
            vram_data_q    <= vram_data_d;
            n_char_we_q    <= n_char_we_d;
            n_attr_we_q    <= n_attr_we_d;
            bus_grant_q    <= bus_grant_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; resetting the pointers and count is what empties the FIFO.
        if (push_accept) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    assign vram_address = vram_address_q;
    assign vram_data    = vram_data_q;
    assign n_char_we    = n_char_we_q;
    assign n_attr_we    = n_attr_we_q;
    assign bus_grant    = bus_grant_q;
    assign fifo_full    = fifo_full_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_vram_write_buffer.sv
// tb_vram_write_buffer
// Directed stimulus for vram_write_buffer. Stimulus pushes the expected VRAM
// write (plane, address, data) into a queue; a monitor pops and compares on
// every observed write-enable strobe.

module tb_vram_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cpu_data;
    logic [1:0]  cpu_address;
    logic        n_write;
    logic        display_active;
    logic [10:0] vram_address;
    logic [7:0]  vram_data;
    logic        n_char_we;
    logic        n_attr_we;
    logic        bus_grant;
    logic        fifo_full;
    logic        overflow;

    typedef struct packed {
        logic        plane;   // 0 = character, 1 = attribute
        logic [10:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   checks       = 0;
    int   errors       = 0;
    int   strobe_count = 0;
    int   base;

    vram_write_buffer #(
        .DEPTH      (4),
        .ADDR_WIDTH (11)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_data       (cpu_data),
        .cpu_address    (cpu_address),
        .n_write        (n_write),
        .display_active (display_active),
        .vram_address   (vram_address),
        .vram_data      (vram_data),
        .n_char_we      (n_char_we),
        .n_attr_we      (n_attr_we),
        .bus_grant      (bus_grant),
        .fifo_full      (fifo_full),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every strobe seen on the VRAM side must match the queue head.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (reset === 1'b0 && (n_char_we === 1'b0 || n_attr_we === 1'b0)) begin
            strobe_count++;
            got.plane = (n_attr_we === 1'b0);
            got.addr  = vram_address;
            got.data  = vram_data;
            check("strobe_single_we", {31'd0, n_char_we ^ n_attr_we}, 32'd1);
            check("strobe_grant", {31'd0, bus_grant}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got 0x%0h, expected no write", got);
            end else begin
                want = exp_q.pop_front();
                check("write_entry", {12'd0, got}, {12'd0, want});
            end
        end
    end

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_address = a;
        cpu_data    = d;
        n_write     = 1'b0;
        @(negedge clk);
        n_write     = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        cycles(3);
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic wait_strobe(input string name);
        int k = 0;
        while (n_char_we === 1'b1 && n_attr_we === 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, (k < 100)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        cpu_data       = 8'h00;
        cpu_address    = 2'd0;
        n_write        = 1'b1;
        display_active = 1'b0;

        // Reset state.
        cycles(3);
        check("rst_vram_address", {21'd0, vram_address}, 32'h0);
        check("rst_vram_data", {24'd0, vram_data}, 32'h0);
        check("rst_n_char_we", {31'd0, n_char_we}, 32'd1);
        check("rst_n_attr_we", {31'd0, n_attr_we}, 32'd1);
        check("rst_bus_grant", {31'd0, bus_grant}, 32'd0);
        check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cycles(2);

        // Basic char + attr write, display inactive.
        cpu_write(2'd0, 8'h34);
        cpu_write(2'd1, 8'h01);
        exp_q.push_back('{plane: 1'b0, addr: 11'h134, data: 8'h41});
        cpu_write(2'd2, 8'h41);
        exp_q.push_back('{plane: 1'b1, addr: 11'h134, data: 8'h1F});
        cpu_write(2'd3, 8'h1F);
        drain("t1_drain");

        // Latency of a single write into an empty FIFO; also proves pointer = 0x135.
        exp_q.push_back('{plane: 1'b0, addr: 11'h135, data: 8'h55});
        @(negedge clk);
        cpu_address = 2'd2;
        cpu_data    = 8'h55;
        n_write     = 1'b0;
        @(negedge clk);
        n_write = 1'b1;
        check("lat_n1_no_grant", {31'd0, bus_grant}, 32'd0);
        @(negedge clk);
        check("lat_setup_grant", {31'd0, bus_grant}, 32'd1);
        check("lat_setup_we", {30'd0, n_char_we, n_attr_we}, 32'd3);
        check("lat_setup_addr", {21'd0, vram_address}, 32'h135);
        @(negedge clk);
        check("lat_strobe_we", {30'd0, n_char_we, n_attr_we}, 32'd1);
        @(negedge clk);
        check("lat_hold_grant", {31'd0, bus_grant}, 32'd1);
        check("lat_hold_we", {30'd0, n_char_we, n_attr_we}, 32'd3);
        check("lat_hold_data", {24'd0, vram_data}, 32'h55);
        @(negedge clk);
        check("lat_idle_grant", {31'd0, bus_grant}, 32'd0);
        drain("lat_drain");

        // Writes held off while display is active, then drained in order.
        display_active = 1'b1;
        cpu_write(2'd0, 8'h34);
        cpu_write(2'd1, 8'h01);
        exp_q.push_back('{plane: 1'b0, addr: 11'h134, data: 8'h41});
        cpu_write(2'd2, 8'h41);
        exp_q.push_back('{plane: 1'b1, addr: 11'h134, data: 8'h1F});
        cpu_write(2'd3, 8'h1F);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t2_no_grant", {31'd0, bus_grant}, 32'd0);
            check("t2_no_we", {30'd0, n_char_we, n_attr_we}, 32'd3);
        end
        display_active = 1'b0;
        drain("t2_drain");

        // Overflow: six pushes into a 4-deep FIFO with the display active.
        display_active = 1'b1;
        cpu_write(2'd0, 8'h00);
        cpu_write(2'd1, 8'h02);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                exp_q.push_back('{plane: 1'b1, addr: 11'h200 + 11'(i), data: 8'hA0 + 8'(i)});
            end
            cpu_write(2'd3, 8'hA0 + 8'(i));
            if (i == 3) begin
                check("t3_full_after_4", {31'd0, fifo_full}, 32'd1);
                check("t3_no_ovf_after_4", {31'd0, overflow}, 32'd0);
            end
            if (i == 4) begin
                check("t3_ovf_after_5", {31'd0, overflow}, 32'd1);
            end
        end
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        cpu_write(2'd1, 8'h02);
        check("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
        check("t3_still_full", {31'd0, fifo_full}, 32'd1);
        display_active = 1'b0;
        drain("t3_drain");
        check("t3_not_full", {31'd0, fifo_full}, 32'd0);
        // Pointer kept incrementing on dropped pushes: 0x200 + 6.
        exp_q.push_back('{plane: 1'b0, addr: 11'h206, data: 8'h77});
        cpu_write(2'd2, 8'h77);
        drain("t3_ptr_drain");

        // Pointer wrap 0x7FF -> 0x000.
        cpu_write(2'd0, 8'hFF);
        cpu_write(2'd1, 8'h07);
        exp_q.push_back('{plane: 1'b1, addr: 11'h7FF, data: 8'h5A});
        cpu_write(2'd3, 8'h5A);
        exp_q.push_back('{plane: 1'b0, addr: 11'h000, data: 8'h66});
        cpu_write(2'd2, 8'h66);
        drain("t4_drain");

        // display_active rising during STROBE: cycle completes, no new SETUP.
        display_active = 1'b1;
        exp_q.push_back('{plane: 1'b0, addr: 11'h000, data: 8'h11});
        cpu_write(2'd2, 8'h11);
        exp_q.push_back('{plane: 1'b0, addr: 11'h000, data: 8'h22});
        cpu_write(2'd2, 8'h22);
        base = strobe_count;
        display_active = 1'b0;
        wait_strobe("t5_strobe_seen");
        display_active = 1'b1;
        @(negedge clk);
        check("t5_hold_grant", {31'd0, bus_grant}, 32'd1);
        check("t5_hold_we", {30'd0, n_char_we, n_attr_we}, 32'd3);
        @(negedge clk);
        check("t5_idle_grant", {31'd0, bus_grant}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_held_off", {31'd0, bus_grant}, 32'd0);
        end
        check("t5_one_write", strobe_count - base, 32'd1);
        display_active = 1'b0;
        drain("t5_drain");

        // Reset during STROBE with three entries queued.
        display_active = 1'b1;
        exp_q.push_back('{plane: 1'b0, addr: 11'h000, data: 8'h31});
        cpu_write(2'd2, 8'h31);
        cpu_write(2'd2, 8'h32);
        cpu_write(2'd2, 8'h33);
        display_active = 1'b0;
        wait_strobe("t6_strobe_seen");
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_we", {30'd0, n_char_we, n_attr_we}, 32'd3);
        check("t6_rst_grant", {31'd0, bus_grant}, 32'd0);
        base = strobe_count;
        @(negedge clk);
        reset = 1'b0;
        cycles(30);
        check("t6_no_writes", strobe_count - base, 32'd0);
        check("t6_not_full", {31'd0, fifo_full}, 32'd0);
        check("t6_grant_low", {31'd0, bus_grant}, 32'd0);
        check("t6_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_write_buffer.md
# vram_write_buffer

CPU-side write port for text-mode VRAM. It is the writer end of the VRAM interface that the CRTC reads from. CPU writes are posted into a small FIFO. The FIFO is drained into the character and attribute planes only while the CRTC is outside the active display area, so the CPU never contends with character fetches. It sits beside the CRTC, and its `bus_grant` output steers the external VRAM address/data multiplexer.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two, 2..16).
- `ADDR_WIDTH`, 11: VRAM address width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock (pixel clock domain).
- `reset`  in  1  async active-high reset.
- `cpu_data`  in  8  CPU data bus.
- `cpu_address`  in  2  register select.
- `n_write`  in  1  active-low write strobe from decode logic, synchronous to `clk`.
- `display_active`  in  1  high while the CRTC may fetch from VRAM. The integrator drives it high at least one `clk` before the first fetch of a line.
- `vram_address`  out  ADDR_WIDTH  VRAM address while granted.
- `vram_data`  out  8  VRAM write data while granted.
- `n_char_we`  out  1  active-low character-plane write enable.
- `n_attr_we`  out  1  active-low attribute-plane write enable.
- `bus_grant`  out  1  high while this block owns the VRAM bus.
- `fifo_full`  out  1  FIFO holds DEPTH entries.
- `overflow`  out  1  sticky flag; set when a write is dropped.

## Operation
- Write event:
  - A write is the cycle in which `n_write` is low and was high the previous cycle (falling-edge detect on a registered copy).
  - A strobe held low for several cycles produces one event.
  - `cpu_address` and `cpu_data` are sampled in the event cycle.
- Register map:
  - 0: address pointer bits [7:0].
  - 1: address pointer bits [10:8] from `cpu_data[2:0]`; also clears `overflow`.
  - 2: push {plane=char, pointer, data}. Pointer unchanged.
  - 3: push {plane=attr, pointer, data}. Pointer then increments by 1, wrapping 2047 -> 0.
- Push acceptance:
  - A push is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped, `overflow` is set, and the pointer still increments on register 3.
- FIFO:
  - Circular, with DEPTH-wide storage of {plane, address, data}.
  - Count is DEPTH-clog2+1 bits.
  - Pop occurs in the HOLD->IDLE transition.
- FSM states:
  - IDLE: outputs inactive, `bus_grant`=0. Go to SETUP when the FIFO is non-empty and `display_active`=0.
  - SETUP: `bus_grant`=1; `vram_address`/`vram_data` driven from the FIFO head; both write enables high. Go to STROBE.
  - STROBE: the write enable of the head entry's plane is low; the other stays high. Go to HOLD.
  - HOLD: write enables high; address/data held; `bus_grant`=1. Pop, then go to IDLE.
- A started cycle always completes, even if `display_active` rises mid-cycle. `display_active` is checked only in IDLE.
- `vram_address`/`vram_data` retain their last values when not granted.

## Timing
- All outputs are registered.
- Reset values: `vram_address`=0, `vram_data`=0, `n_char_we`=1, `n_attr_we`=1, `bus_grant`=0, `fifo_full`=0, `overflow`=0, pointer=0, FIFO empty, FSM in IDLE.
- Latency from write event in cycle N, with FIFO previously empty and `display_active`=0:
  - entry valid at N+1;
  - SETUP at N+2;
  - STROBE at N+3;
  - HOLD at N+4;
  - IDLE at N+5 with the FIFO empty.
- Throughput: one VRAM write per 4 cycles (SETUP, STROBE, HOLD, IDLE), with a minimum one-cycle gap of `bus_grant`=0 between writes.
- `fifo_full` updates the cycle after the push or pop that changes count.
- Reset asserted mid-write: write enables go high and `bus_grant` goes low immediately (async); the FIFO is flushed.

## Test plan
- Write 0x34 to reg 0, 0x01 to reg 1, 0x41 to reg 2, 0x1F to reg 3, with `display_active`=0.
  -> Two write cycles: `n_char_we` pulses with address 0x134 / data 0x41, then `n_attr_we` pulses with address 0x134 / data 0x1F. Pointer becomes 0x135.
- Same writes with `display_active`=1, released 20 cycles later.
  -> No write enable and `bus_grant`=0 while active. The writes occur in order after release.
- Six data writes with DEPTH=4 and `display_active`=1.
  -> `fifo_full`=1 after the 4th; `overflow`=1 after the 5th. Only the first 4 entries reach VRAM. A write to reg 1 clears `overflow`.
- Pointer at 0x7FF, write reg 3.
  -> Write to 0x7FF; pointer wraps to 0x000.
- `display_active` rises during STROBE.
  -> Cycle completes through HOLD. No new SETUP until `display_active`=0.
- Reset during STROBE with 3 entries queued.
  -> Write enables high and `bus_grant`=0 immediately. After reset, no writes occur and `fifo_full`=0.
